mul_div_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit sitting directly upstream of the register file write port.

---
 rtl/mul_div_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit feeding the register
//               file write port. Shift-add multiplier and restoring divider
//               share one hi/lo datapath. Optional MULDIV_EARLY_OUT_EN skips
//               the iteration for trivial/special operands.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_addr,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_min      = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d;
    logic [XLEN-1:0] b_mag_q, b_mag_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_q, neg_d;
    logic            rneg_q, rneg_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div_zero, w_ovf, w_mul_zero;
    logic [XLEN:0]   w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0] w_quo, w_rem, w_result;

    // Operand conditioning: funct3 1,2,4,6 treat a as signed; 1,4,6 treat b as signed.
    assign w_a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_b_signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_a_neg    = w_a_signed && rs1_val[XLEN-1];
    assign w_b_neg    = w_b_signed && rs2_val[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~rs1_val + 1'b1) : rs1_val;
    assign w_b_mag    = w_b_neg ? (~rs2_val + 1'b1) : rs2_val;
    assign w_div_zero = funct3[2] && (rs2_val == '0);
    assign w_ovf      = funct3[2] && !funct3[0] && (rs1_val == c_min) && (rs2_val == '1);
    assign w_mul_zero = !funct3[2] && ((rs1_val == '0) || (rs2_val == '0));

    assign w_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag_q} : {(XLEN+1){1'b0}});
    assign w_shift = {hi_q, lo_q[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, b_mag_q};

    assign w_prod   = {hi_q, lo_q};
    assign w_prod_s = neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign w_rem    = rneg_q ? (~hi_q + 1'b1) : hi_q;

    always_comb begin
        w_result = '0;
        case (funct3_q)
            3'd0:          w_result = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_result = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (div_zero_q)  w_result = '1;
                else if (ovf_q)  w_result = c_min;
                else             w_result = w_quo;
            end
            default: begin
                // Remainder by zero returns the original dividend.
                if (div_zero_q)  w_result = rneg_q ? (~a_mag_q + 1'b1) : a_mag_q;
                else if (ovf_q)  w_result = '0;
                else             w_result = w_rem;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct3_d   = funct3_q;
        a_mag_d    = a_mag_q;
        b_mag_d    = b_mag_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    funct3_d   = funct3;
                    wb_addr_d  = rd_addr;
                    a_mag_d    = w_a_mag;
                    b_mag_d    = w_b_mag;
                    neg_d      = w_a_neg ^ w_b_neg;
                    rneg_d     = w_a_neg;
                    div_zero_d = w_div_zero;
                    ovf_d      = w_ovf;
                    hi_d       = '0;
                    lo_d       = funct3[2] ? w_a_mag : w_b_mag;
                    cnt_d      = '0;
                    state_d    = c_st_calc;
`ifdef MULDIV_EARLY_OUT_EN
                    if (w_mul_zero) begin
                        lo_d = '0;
                    end
                    if (w_div_zero || w_ovf || w_mul_zero) begin
                        state_d = c_st_fix;
                    end
`endif
                end
            end
            c_st_calc: begin
                if (funct3_q[2]) begin
                    // Restoring step: keep the trial difference when it did not borrow.
                    if (!w_diff[XLEN]) begin
                        hi_d = w_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = w_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = w_sum[XLEN:1];
                    lo_d = {w_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == c_cnt_last) begin
                    cnt_d   = '0;
                    state_d = c_st_fix;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_st_fix: begin
                wb_data_d = w_result;
                state_d   = c_st_done;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= c_st_idle;
            cnt_q      <= '0;
            funct3_q   <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct3_q   <= funct3_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign busy    = (state_q != c_st_idle);
    assign done    = (state_q == c_st_done);
    assign wb_we   = done && (wb_addr_q != 5'd0);
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed + random scoreboard bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        we;
        int          lat;
    } item_t;

    item_t sb[$];

    mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
        .busy(busy), .done(done), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        logic signed [31:0] sa, sb_;
        sa  = a;
        sb_ = b;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'd2: begin x = {{32{a[31]}}, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'd3: begin x = {32'd0, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb_;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb_;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges counted after the accepting edge until done is first seen high.
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (f3[2] && b == 0) ||
                  ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                  (!f3[2] && (a == 0 || b == 0));
`ifdef MULDIV_EARLY_OUT_EN
        return special ? 1 : 33;
`else
        return special ? 33 : 33;
`endif
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit repulse);
        item_t it;
        int    lat;
        int    extra;
        bit    got;
        it.data = exp;
        it.addr = rd;
        it.we   = (rd != 0);
        it.lat  = exp_lat(f3, a, b);
        sb.push_back(it);
        @(negedge clk);
        funct3 = f3; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 60) begin
            start = (repulse && lat == 4);
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        start = 1'b0;
        it = sb.pop_front();
        check("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check("latency", lat, it.lat);
            check("wb_data", wb_data, it.data);
            check("wb_addr", {27'd0, wb_addr}, {27'd0, it.addr});
            check("wb_we", {31'd0, wb_we}, {31'd0, it.we});
        end
        extra = 0;
        for (int i = 0; i < (repulse ? 40 : 3); i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("extra_done", extra, 0);
        check("idle_after", {31'd0, busy}, 32'd0);
        check("wb_data_held", wb_data, it.data);
    endtask

    initial begin
        int dcount;
        logic [31:0] ra, rb;
        logic [2:0]  rf;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wb_we", {31'd0, wb_we}, 32'd0);
        check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1'b0);
        run_op(3'd5, 32'd9, 32'd0, 5'd15, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd7, 32'd9, 32'd0, 5'd16, 32'd9, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd17, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd18, 32'hFFFF_FFF9, 1'b0);
        run_op(3'd0, 32'd0, 32'h1234_5678, 5'd19, 32'd0, 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'd0, 5'd20, 32'd0, 1'b0);
        run_op(3'd0, 32'd3, 32'd5, 5'd21, 32'd15, 1'b1);
        run_op(3'd0, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? 32'd0 : $urandom;
            rf = 3'($urandom_range(0, 7));
            run_op(rf, ra, rb, 5'($urandom_range(1, 31)), ref_model(rf, ra, rb), 1'b0);
        end

        // Reset asserted mid-iteration: outputs clear at once and no write-back follows.
        @(negedge clk);
        funct3 = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd_addr = 5'd22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_wb_we", {31'd0, wb_we}, 32'd0);
        check("midrst_wb_addr", {27'd0, wb_addr}, 32'd0);
        check("midrst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || wb_we || busy) dcount++;
        end
        check("midrst_no_wb", dcount, 0);

        run_op(3'd5, 32'd100, 32'd7, 5'd23, 32'd14, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
